// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared widths, FSM state type and one-hot helper for the 4:1 mux arbiter
package mux_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {IDLE, GRANT} state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin search for the first set request after the last owner
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);
    logic [SEL_W-1:0] p1, p2, p3;

    // candidates in priority order: ptr+1, ptr+2, ptr+3, then ptr itself
    always_comb begin
        p1   = ptr + 2'd1;
        p2   = ptr + 2'd2;
        p3   = ptr + 2'd3;
        pick = req[p1] ? p1 : req[p2] ? p2 : req[p3] ? p3 : ptr;
        any  = |req;
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a registered 4:1 mux with bounded hold time
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       done,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [1:0]       sel,
    output logic [3:0]       gnt,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [7:0]       hold_cnt;
    logic [SEL_W-1:0] pick;
    logic             any;
    logic             rel_now;
    logic [WIDTH-1:0] lane;

    rr_pick u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    // ptr always names the owner while granted; any release cause ends the grant once
    always_comb begin
        rel_now = done[ptr] | ~req[ptr] | (hold_cnt == HOLD_LAST);
        lane    = (sel == 2'd0) ? a : (sel == 2'd1) ? b : (sel == 2'd2) ? c : d;
    end

    // arbitration FSM: grant on request, release on done/drop/timeout, bubble in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            ptr      <= 2'd3;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    if (any) begin
                        state    <= GRANT;
                        gnt      <= onehot(pick);
                        sel      <= pick;
                        ptr      <= pick;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (rel_now) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // output register: capture the owner's lane one cycle behind the grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= (state == GRANT);
            if (state == GRANT) y <= lane;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed checks of arbitration, timing, release and reset
module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic [1:0] sel8, sel2;
    logic [3:0] gnt8, gnt2;
    logic       y8, y2, yv8, yv2;
    int         errors = 0;
    int         checks = 0;

    mux4_rr_arbiter #(.WIDTH(1), .MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst), .req(req), .done(done), .a(a), .b(b), .c(c), .d(d),
        .sel(sel8), .gnt(gnt8), .y(y8), .y_valid(yv8)
    );

    mux4_rr_arbiter #(.WIDTH(1), .MAX_HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .done(done), .a(a), .b(b), .c(c), .d(d),
        .sel(sel2), .gnt(gnt2), .y(y2), .y_valid(yv2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        done = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_gnt [13];
        logic [1:0] rr_sel [13];
        rr_gnt = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
        rr_sel = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};

        // reset and idle
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_gnt", gnt8, 4'h0);
            check("idle_sel", sel8, 2'd0);
            check("idle_y", y8, 1'b0);
            check("idle_yv", yv8, 1'b0);
        end

        // single requester, MAX_HOLD=8
        a = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            step();
            check("single_gnt", gnt8, 4'h1);
            check("single_sel", sel8, 2'd0);
            check("single_yv", yv8, i > 0);
            if (i > 0) check("single_y", y8, 1'b1);
        end
        step();
        check("single_bubble_gnt", gnt8, 4'h0);
        check("single_bubble_yv", yv8, 1'b1);
        step();
        check("single_regrant", gnt8, 4'h1);
        check("single_regrant_yv", yv8, 1'b0);
        req = 4'b0000;
        step();
        check("single_drop_gnt", gnt8, 4'h0);
        check("single_drop_yv", yv8, 1'b1);
        step();
        check("single_drop_yv2", yv8, 1'b0);
        a = 1'b0;

        // round-robin fairness, MAX_HOLD=2
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            step();
            check("rr_gnt", gnt2, rr_gnt[i]);
            check("rr_sel", sel2, rr_sel[i]);
        end

        // early release of lane 2; non-owner done ignored
        do_reset();
        req = 4'b0100;
        step();
        check("early_g1", gnt8, 4'h4);
        check("early_sel", sel8, 2'd2);
        done = 4'b0001;
        step();
        check("early_g2_nonowner_done", gnt8, 4'h4);
        done = 4'b0000;
        step();
        check("early_g3", gnt8, 4'h4);
        done = 4'b0100;
        step();
        check("early_released", gnt8, 4'h0);
        done = 4'b0000;
        step();
        check("early_regrant", gnt8, 4'h4);

        // priority rotation: after lane 1, lane 3 outranks lane 0
        do_reset();
        req = 4'b0010;
        step();
        check("rot_g1", gnt8, 4'h2);
        req = 4'b1011;
        done = 4'b0010;
        step();
        check("rot_release", gnt8, 4'h0);
        done = 4'b0000;
        step();
        check("rot_next_gnt", gnt8, 4'h8);
        check("rot_next_sel", sel8, 2'd3);

        // asynchronous reset in the middle of lane 1's grant
        do_reset();
        b = 1'b1;
        req = 4'b0010;
        step();
        check("mid_gnt", gnt8, 4'h2);
        step();
        check("mid_y", y8, 1'b1);
        check("mid_yv", yv8, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_gnt", gnt8, 4'h0);
        check("mid_rst_y", y8, 1'b0);
        check("mid_rst_yv", yv8, 1'b0);
        check("mid_rst_sel", sel8, 2'd0);
        req = 4'b1111;
        #1;
        rst = 1'b0;
        step();
        check("mid_after_gnt", gnt8, 4'h1);
        check("mid_after_sel", sel8, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Sequencer and arbiter for the 4:1 mux datapath (four lanes a/b/c/d, 2-bit select, output y).
- Shares the mux output between four requesters using round-robin fairness, holds a grant for up to MAX_HOLD cycles, and drives sel.
- Registers the selected lane onto y and flags it with y_valid.
- Sits between the four lane producers and the single downstream consumer of y.

Parameters:
- WIDTH, 1, bit width of each data lane and of y.
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold a grant (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  request per lane; bit i corresponds to lane i (0=a, 1=b, 2=c, 3=d).
- done  input  4  release strobe per lane; only the current owner's bit is honoured.
- a  input  WIDTH  lane 0 data.
- b  input  WIDTH  lane 1 data.
- c  input  WIDTH  lane 2 data.
- d  input  WIDTH  lane 3 data.
- sel  output  2  mux select; equals the index of the current or last owner.
- gnt  output  4  one-hot grant, or all-zero when idle.
- y  output  WIDTH  registered mux output.
- y_valid  output  1  y holds owner data this cycle.

Behaviour:
- Reset values (asynchronous, applied immediately when rst rises): state=IDLE, gnt=0, sel=0, y=0, y_valid=0, hold_cnt=0, last-owner pointer ptr=3, so lane 0 has first priority.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req!=0 at a clock edge: pick the first set req bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - On the same edge: state→GRANT, gnt=onehot(pick), sel=pick, ptr=pick, hold_cnt=0.
  - If req=0: stay in IDLE; gnt=0; sel keeps its last value.
- GRANT, release condition is any of:
  - done[owner]=1;
  - req[owner]=0;
  - hold_cnt==MAX_HOLD-1.
- GRANT, on release: state→IDLE, gnt=0, hold_cnt=0. One idle bubble cycle always follows a release.
- GRANT, otherwise: hold_cnt increments by 1 and the grant is unchanged.
- Simultaneous release causes (done, req drop, timeout) are a single release event; no double counting.
- done or req changes on non-owner bits during GRANT are ignored.
- Datapath:
  - Each edge: y <= lane[sel] if state==GRANT, else y holds its value.
  - y_valid <= (state==GRANT).
- Latency:
  - req sampled at edge N → gnt/sel valid after edge N.
  - y/y_valid valid after edge N+1.
  - y_valid deasserts one cycle after gnt drops.
- Timeout:
  - A requester holding req continuously gets exactly MAX_HOLD grant cycles.
  - It is then released and becomes lowest priority at the next arbitration.
  - MAX_HOLD=1 gives single-cycle grants.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,… and each grant is MAX_HOLD cycles followed by a 1-cycle bubble.
- gnt is always one-hot or zero, and sel==index(gnt) whenever gnt!=0.
- Reset mid-GRANT: gnt, y_valid and y clear immediately; ptr returns to 3; the interrupted owner gets no priority credit.

Decomposition:
- Package mux_arb_pkg:
  - NUM_REQ=4, SEL_W=2;
  - state type {IDLE, GRANT};
  - function onehot(idx).
- One combinational sub-module, rr_pick: inputs req[3:0] and ptr[1:0]; outputs pick[1:0] and any. The top block holds the FSM, hold counter, ptr, and output register.

Test Plan:
- Reset/idle: rst=1 then 0 with req=0 → gnt=0, sel=0, y=0, y_valid=0 for 5 cycles.
- Single requester: a=1, b=c=d=0, req=0001, done=0, MAX_HOLD=8 → gnt=0001 and sel=0 for 8 cycles, y=1 with y_valid=1 lagging gnt by one cycle, then 1 bubble cycle (gnt=0), then re-granted.
- Round-robin: req=1111 held with MAX_HOLD=2 → gnt sequence 0001,0001,0,0010,0010,0,0100,0100,0,1000,1000,0,0001; sel follows 0,1,2,3.
- Early release: owner=lane 2, done=0100 pulsed on the 3rd grant cycle → gnt=0 the next cycle; done=0001 pulsed during lane 2's grant has no effect.
- Priority rotation: ptr=1 after lane 1's grant, then req=1011 → next grant is lane 3, not lane 0.
- Reset mid-grant: assert rst asynchronously mid-cycle while gnt=0010 → gnt, y, y_valid go to 0 before the next edge; after release with req=1111, the first grant is lane 0.
